// File: rtl/i2c_target_if.sv
// User-side handshake of the I2C target: received bytes out, read bytes in.
// The target attaches through the slave modport and the user logic through the master modport.
interface i2c_target_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       busy;

    modport slave  (output rx_data, rx_valid, tx_req, busy, input  tx_data);
    modport master (input  rx_data, rx_valid, tx_req, busy, output tx_data);
endinterface

// File: rtl/i2c_target.sv
// I2C target with a fixed 7-bit address. SCL/SDA are oversampled on clk, and SDA is driven open-drain only.
// No clock stretching. Write bytes go out as rx_data/rx_valid; read bytes are requested with tx_req.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | bus free, waiting for START
// ADDR      | shifting 7 address bits + R/W
// ADDR_ACK  | driving ACK for the address; on a read, fetch the first byte
// WRITE     | shifting a byte written by the master
// WRITE_ACK | driving ACK for a written byte
// READ      | shifting a read byte out on SDA
// READ_ACK  | released SDA, sampling the master's ACK/NACK
// WAIT_STOP | not addressed or NACKed; only START/STOP leave
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'b1000100,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i2c_scl,
    inout  wire         i2c_sda,
    i2c_target_if.slave user
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_q;
    logic                   sda_q;
    logic [3:0]             bit_cnt;
    logic [7:0]             shreg;
    logic                   rw;
    logic                   m_ack;
    logic                   sda_oe;
    logic [7:0]             rx_data_r;
    logic                   rx_valid_r;
    logic                   tx_req_r;
    logic                   busy_r;

    wire scl_s = scl_sync[SYNC_STAGES-1];
    wire sda_s = sda_sync[SYNC_STAGES-1];

    wire scl_rise  =  scl_s & ~scl_q;
    wire scl_fall  = ~scl_s &  scl_q;
    wire start_det =  scl_s &  scl_q &  sda_q & ~sda_s;
    wire stop_det  =  scl_s &  scl_q & ~sda_q &  sda_s;

    assign i2c_sda       = sda_oe ? 1'b0 : 1'bz;
    assign user.rx_data  = rx_data_r;
    assign user.rx_valid = rx_valid_r;
    assign user.tx_req   = tx_req_r;
    assign user.busy     = busy_r;

    // Synchronizers reset to the idle-bus level so that leaving reset creates no false edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync <= {SYNC_STAGES{1'b1}};
            sda_sync <= {SYNC_STAGES{1'b1}};
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_sda};
            scl_q    <= scl_s;
            sda_q    <= sda_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            bit_cnt    <= 4'd0;
            shreg      <= 8'h00;
            rw         <= 1'b0;
            m_ack      <= 1'b0;
            sda_oe     <= 1'b0;
            rx_data_r  <= 8'h00;
            rx_valid_r <= 1'b0;
            tx_req_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            tx_req_r   <= 1'b0;
            if (start_det) begin
                state   <= ADDR;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
                m_ack   <= 1'b0;
            end else if (stop_det) begin
                state   <= IDLE;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
                m_ack   <= 1'b0;
                busy_r  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        sda_oe <= 1'b0;
                    end
                    ADDR: begin
                        if (scl_rise) begin
                            shreg <= {shreg[6:0], sda_s};
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= 4'd8;
                                if (shreg[6:0] == TARGET_ADDR) begin
                                    busy_r <= 1'b1;
                                    rw     <= sda_s;
                                    state  <= ADDR_ACK;
                                end else begin
                                    busy_r <= 1'b0;
                                    state  <= WAIT_STOP;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    // sda_oe doubles as the phase flag: first fall starts the ACK, second ends it.
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                bit_cnt <= 4'd0;
                                if (rw) begin
                                    shreg  <= user.tx_data;
                                    sda_oe <= ~user.tx_data[7];
                                    state  <= READ;
                                end else begin
                                    sda_oe <= 1'b0;
                                    state  <= WRITE;
                                end
                            end
                        end else if (scl_rise && sda_oe && rw) begin
                            tx_req_r <= 1'b1;
                        end
                    end
                    WRITE: begin
                        if (scl_rise) begin
                            shreg <= {shreg[6:0], sda_s};
                            if (bit_cnt == 4'd7) begin
                                bit_cnt    <= 4'd8;
                                rx_data_r  <= {shreg[6:0], sda_s};
                                rx_valid_r <= 1'b1;
                                state      <= WRITE_ACK;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    WRITE_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 4'd0;
                                state   <= WRITE;
                            end
                        end
                    end
                    // Bit 7 is already on the line on entry; each fall presents the next bit.
                    READ: begin
                        if (scl_rise) begin
                            if (bit_cnt != 4'd8) bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe <= 1'b0;
                                state  <= READ_ACK;
                            end else begin
                                shreg  <= {shreg[6:0], 1'b0};
                                sda_oe <= ~shreg[6];
                            end
                        end
                    end
                    READ_ACK: begin
                        if (scl_rise) begin
                            if (!sda_s) begin
                                m_ack    <= 1'b1;
                                tx_req_r <= 1'b1;
                            end else begin
                                busy_r <= 1'b0;
                                state  <= WAIT_STOP;
                            end
                        end else if (scl_fall && m_ack) begin
                            m_ack   <= 1'b0;
                            bit_cnt <= 4'd0;
                            shreg   <= user.tx_data;
                            sda_oe  <= ~user.tx_data[7];
                            state   <= READ;
                        end
                    end
                    WAIT_STOP: begin
                        sda_oe <= 1'b0;
                    end
                    default: begin
                        state  <= IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
